// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-stage access block.
package mem_stage_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic [2:0] ALIGN_MASK = 3'b111;
    localparam int         RD_W       = 5;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Counts WAIT cycles without a memory acknowledge; flags the last permitted cycle.
module mem_timeout_ctr #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int            W    = $clog2(TIMEOUT) + 1;
    localparam logic [W-1:0]  LAST = W'(TIMEOUT - 1);

    logic [W-1:0] cnt;

    // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expire = (cnt == LAST);

endmodule

// File: rtl/mem_stage_access.sv
// MEM pipeline stage: handshaked load/store with stall, timeout and a one-cycle retire pulse.
module mem_stage_access
    import mem_stage_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 64,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              RegWrite,
    input  logic              MemtoReg,
    input  logic              MemWrite,
    input  logic              MemRead,
    input  logic [ADDR_W-1:0] AluResult,
    input  logic [DATA_W-1:0] DataIn,
    input  logic [RD_W-1:0]   Rd_in,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              valid_out,
    output logic              RegWrite_Out,
    output logic              MemtoReg_Out,
    output logic [ADDR_W-1:0] AluOut,
    output logic [DATA_W-1:0] ReadData,
    output logic [RD_W-1:0]   Rd_out,
    output logic              misaligned,
    output logic              bus_error
);

    state_t state, state_next;

    logic mem_op, aligned, expire;
    logic accept, retire_alu, retire_mis, retire_ack, retire_to;

    // Controls held for the instruction while its access is outstanding
    logic            cap_reg_write;
    logic            cap_memto_reg;
    logic [RD_W-1:0] cap_rd;

    assign mem_op  = MemRead | MemWrite;
    assign aligned = ((AluResult[2:0] & ALIGN_MASK) == 3'b000);

    mem_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (reset),
        .clear  (state == IDLE),
        .enable ((state == WAIT) && !mem_ack),
        .expire (expire)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = WAIT;
            WAIT:    if (retire_ack || retire_to) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        accept     = 1'b0;
        retire_alu = 1'b0;
        retire_mis = 1'b0;
        retire_ack = 1'b0;
        retire_to  = 1'b0;
        stall      = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (!mem_op)       retire_alu = 1'b1;
                    else if (!aligned) retire_mis = 1'b1;
                    else begin
                        accept = 1'b1;
                        stall  = 1'b1;
                    end
                end
            end
            WAIT: begin
                retire_ack = mem_ack;
                retire_to  = !mem_ack && expire;
                stall      = !mem_ack && !expire;
            end
            default: ;
        endcase
    end

    // NOTE: asynchronous reset clears every output and capture register; reset mid-WAIT drops the access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            valid_out     <= 1'b0;
            RegWrite_Out  <= 1'b0;
            MemtoReg_Out  <= 1'b0;
            AluOut        <= '0;
            ReadData      <= '0;
            Rd_out        <= '0;
            misaligned    <= 1'b0;
            bus_error     <= 1'b0;
            cap_reg_write <= 1'b0;
            cap_memto_reg <= 1'b0;
            cap_rd        <= '0;
        end else begin
            valid_out <= retire_alu | retire_mis | retire_ack | retire_to;

            if (retire_alu || retire_mis) begin
                RegWrite_Out <= RegWrite & !retire_mis;
                MemtoReg_Out <= MemtoReg;
                AluOut       <= AluResult;
                ReadData     <= '0;
                Rd_out       <= Rd_in;
            end
            if (retire_mis) misaligned <= 1'b1;

            if (accept) begin
                mem_req       <= 1'b1;
                mem_we        <= MemWrite;
                mem_addr      <= AluResult;
                mem_wdata     <= DataIn;
                // A combined read+write behaves as a store and never writes Rd
                cap_reg_write <= RegWrite & !MemWrite;
                cap_memto_reg <= MemtoReg;
                cap_rd        <= Rd_in;
            end

            if (retire_ack || retire_to) begin
                mem_req      <= 1'b0;
                RegWrite_Out <= cap_reg_write & retire_ack;
                MemtoReg_Out <= cap_memto_reg;
                AluOut       <= mem_addr;
                ReadData     <= (retire_ack && !mem_we) ? mem_rdata : '0;
                Rd_out       <= cap_rd;
            end
            if (retire_to) bus_error <= 1'b1;
        end
    end

endmodule
